// File: rtl/hv_efuse_load_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hv_efuse_load_ctrl_if
//  Brief    : Request/status, eFuse macro read bus and register-bank write bus
//             of the eFuse load controller, grouped for one port connection.
//  Revision : 1.0  initial release
// ============================================================================
interface hv_efuse_load_ctrl_if #(
    parameter int EFUSE_DATA_W = 8,
    parameter int EFUSE_ADDR_W = 3
) ();

    // Handshake with the HV control FSM
    logic                    i_efuse_load_req;
    logic                    o_efuse_load_done;
    logic                    o_efuse_vld;
    logic                    o_efuse_busy;

    // eFuse macro read interface
    logic [EFUSE_ADDR_W-1:0] o_efuse_addr;
    logic                    o_efuse_strobe;
    logic [EFUSE_DATA_W-1:0] i_efuse_rdata;

    // Register-bank write interface
    logic                    o_reg_wr_en;
    logic [EFUSE_ADDR_W-1:0] o_reg_wr_addr;
    logic [EFUSE_DATA_W-1:0] o_reg_wr_data;

    // Controller side
    modport master (
        input  i_efuse_load_req,
        input  i_efuse_rdata,
        output o_efuse_load_done,
        output o_efuse_vld,
        output o_efuse_busy,
        output o_efuse_addr,
        output o_efuse_strobe,
        output o_reg_wr_en,
        output o_reg_wr_addr,
        output o_reg_wr_data
    );

    // Environment side (FSM, eFuse macro and register bank)
    modport slave (
        output i_efuse_load_req,
        output i_efuse_rdata,
        input  o_efuse_load_done,
        input  o_efuse_vld,
        input  o_efuse_busy,
        input  o_efuse_addr,
        input  o_efuse_strobe,
        input  o_reg_wr_en,
        input  o_reg_wr_addr,
        input  o_reg_wr_data
    );

endinterface
`default_nettype wire

// File: rtl/hv_efuse_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hv_efuse_load_ctrl
//  Brief    : Reads EFUSE_WORD_NUM words from the eFuse macro with timed
//             address/strobe cycles, copies each word into the register bank
//             and validates the image against the XOR checksum in the last
//             word. All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module hv_efuse_load_ctrl #(
    parameter int EFUSE_WORD_NUM = 8,
    parameter int EFUSE_DATA_W   = 8,
    parameter int EFUSE_ADDR_W   = 3,
    parameter int SETUP_CYC      = 2,
    parameter int STROBE_CYC     = 4,
    parameter int HOLD_CYC       = 1
) (
    input  wire logic            i_clk,
    input  wire logic            i_rst,
    hv_efuse_load_ctrl_if.master bus
);

    // Phase cycle counter only has to reach the longest phase length minus one
    localparam int C_MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int C_MAX    = (C_MAX_SS > HOLD_CYC) ? C_MAX_SS : HOLD_CYC;
    localparam int CYC_W    = (C_MAX > 1) ? $clog2(C_MAX) : 1;

    localparam logic [CYC_W-1:0]        C_SETUP_LAST  = CYC_W'(SETUP_CYC - 1);
    localparam logic [CYC_W-1:0]        C_STROBE_LAST = CYC_W'(STROBE_CYC - 1);
    localparam logic [CYC_W-1:0]        C_HOLD_LAST   = CYC_W'(HOLD_CYC - 1);
    localparam logic [EFUSE_ADDR_W-1:0] C_LAST_WORD   = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t                  state_q;
    logic [CYC_W-1:0]        cyc_q;
    logic [EFUSE_ADDR_W-1:0] word_q;      // also drives the eFuse address
    logic [EFUSE_DATA_W-1:0] data_q;      // word captured at strobe end
    logic [EFUSE_DATA_W-1:0] acc_q;       // XOR of words 0..N-2
    logic                    done_q;
    logic                    vld_q;
    logic                    busy_q;
    logic                    strobe_q;
    logic                    wr_en_q;
    logic [EFUSE_ADDR_W-1:0] wr_addr_q;
    logic [EFUSE_DATA_W-1:0] wr_data_q;

    logic                    w_active;
    logic                    w_req;

    assign w_req    = bus.i_efuse_load_req;
    assign w_active = (state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                      (state_q == ST_HOLD)  || (state_q == ST_WRITE)  ||
                      (state_q == ST_CHECK);

    // Load sequencer: state, counters, datapath and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cyc_q     <= '0;
            word_q    <= '0;
            data_q    <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (w_active && !w_req) begin
                // Request withdrawn mid-load: drop everything, keep vld low
                state_q  <= ST_IDLE;
                cyc_q    <= '0;
                busy_q   <= 1'b0;
                strobe_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_req) begin
                            state_q <= ST_SETUP;
                            cyc_q   <= '0;
                            word_q  <= '0;
                            acc_q   <= '0;
                            vld_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_SETUP: begin
                        if (cyc_q == C_SETUP_LAST) begin
                            state_q  <= ST_STROBE;
                            cyc_q    <= '0;
                            strobe_q <= 1'b1;
                        end else begin
                            cyc_q <= cyc_q + CYC_W'(1);
                        end
                    end
                    ST_STROBE: begin
                        if (cyc_q == C_STROBE_LAST) begin
                            state_q  <= ST_HOLD;
                            cyc_q    <= '0;
                            strobe_q <= 1'b0;
                            data_q   <= bus.i_efuse_rdata;
                        end else begin
                            cyc_q <= cyc_q + CYC_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (cyc_q == C_HOLD_LAST) begin
                            state_q   <= ST_WRITE;
                            cyc_q     <= '0;
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= word_q;
                            wr_data_q <= data_q;
                        end else begin
                            cyc_q <= cyc_q + CYC_W'(1);
                        end
                    end
                    ST_WRITE: begin
                        if (word_q == C_LAST_WORD) begin
                            // Last word is the checksum, not part of the XOR
                            state_q <= ST_CHECK;
                        end else begin
                            acc_q   <= acc_q ^ data_q;
                            word_q  <= word_q + EFUSE_ADDR_W'(1);
                            state_q <= ST_SETUP;
                        end
                    end
                    ST_CHECK: begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        vld_q   <= (acc_q == data_q);
                    end
                    ST_DONE: begin
                        if (!w_req) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_efuse_load_done = done_q;
    assign bus.o_efuse_vld       = vld_q;
    assign bus.o_efuse_busy      = busy_q;
    assign bus.o_efuse_addr      = word_q;
    assign bus.o_efuse_strobe    = strobe_q;
    assign bus.o_reg_wr_en       = wr_en_q;
    assign bus.o_reg_wr_addr     = wr_addr_q;
    assign bus.o_reg_wr_data     = wr_data_q;

endmodule
`default_nettype wire

// File: doc/hv_efuse_load_ctrl.md
Name: hv_efuse_load_ctrl

Overview:
Sequences the on-die eFuse macro read after the HV control FSM raises its eFuse load request while in WAIT_ST. It reads N words through a timed address/strobe interface and writes each word into the register bank. It then validates the image with an XOR checksum and returns the done and valid status. Its done output feeds the FSM's efuse-load-done input, and its valid flag drives the register-bank efuse_vld bit.

Parameters:
EFUSE_WORD_NUM, 8, number of eFuse words; the last word holds the checksum; must be >= 2
EFUSE_DATA_W, 8, eFuse word width
EFUSE_ADDR_W, 3, word address width; must satisfy 2^EFUSE_ADDR_W >= EFUSE_WORD_NUM
SETUP_CYC, 2, cycles the address is stable before the strobe; must be >= 1
STROBE_CYC, 4, strobe high width in cycles; must be >= 1
HOLD_CYC, 1, cycles the address is held after the strobe falls; must be >= 1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_efuse_load_req  in  1  level request from the HV control FSM
o_efuse_load_done  out  1  load complete, level
o_efuse_vld  out  1  checksum matched on the last completed load
o_efuse_busy  out  1  high in every state except IDLE and DONE
o_efuse_addr  out  EFUSE_ADDR_W  word address to the eFuse macro
o_efuse_strobe  out  1  read strobe to the eFuse macro
i_efuse_rdata  in  EFUSE_DATA_W  eFuse macro read data
o_reg_wr_en  out  1  one-cycle register-bank write pulse
o_reg_wr_addr  out  EFUSE_ADDR_W  register-bank word index
o_reg_wr_data  out  EFUSE_DATA_W  captured eFuse word

Behaviour:
- Reset (synchronous, i_rst=1 at a clock edge):
  - state=IDLE.
  - All outputs 0.
  - Word counter, cycle counter, capture register and XOR accumulator cleared.
  - Reset mid-operation aborts immediately; strobe is low from the next edge.
- Output timing: all outputs are registered state or registered data; there is no combinational path from any input to any output.
- States: IDLE, SETUP, STROBE, HOLD, WRITE, CHECK, DONE.
- IDLE:
  - If req=1: go to SETUP, clear word counter and accumulator, clear o_efuse_vld.
- SETUP:
  - o_efuse_addr = word counter.
  - Stay SETUP_CYC cycles, then go to STROBE.
- STROBE:
  - o_efuse_strobe=1 for exactly STROBE_CYC cycles.
  - On the edge leaving STROBE, capture i_efuse_rdata into the data register.
  - Then go to HOLD.
- HOLD:
  - Strobe=0, address unchanged.
  - Stay HOLD_CYC cycles, then go to WRITE.
- WRITE (one cycle):
  - o_reg_wr_en=1, o_reg_wr_addr = word counter, o_reg_wr_data = captured word.
  - If word counter < N-1: XOR the captured word into the accumulator.
  - If word counter == N-1: go to CHECK.
  - Otherwise: increment word counter and go to SETUP. The counter never wraps.
- CHECK (one cycle):
  - Compare the accumulator with the last captured word.
  - On the edge entering DONE, o_efuse_vld <= match.
- DONE:
  - o_efuse_load_done=1, held while req=1.
  - When req=0: go to IDLE; done=0 from the next edge.
  - o_efuse_vld holds until the next load starts or reset.
- Request dropped early: if req=0 in any of SETUP, STROBE, HOLD, WRITE or CHECK, go to IDLE on that edge.
  - No register write is issued from the abort edge onward.
  - done stays 0 and o_efuse_vld stays 0.
- Request re-raised in IDLE: starts a full new load from word 0.
- Latency:
  - Per word: W = SETUP_CYC + STROBE_CYC + HOLD_CYC + 1 cycles.
  - done rises EFUSE_WORD_NUM*W + 1 edges after the edge on which IDLE samples req=1.
  - With the defaults: W=8, so done rises at edge 65.
- o_efuse_busy = (state != IDLE) && (state != DONE).

Test Plan:
1. Nominal load: eFuse words 0..6 = 0x11..0x17, word 7 = 0x11^…^0x17 = 0x10, req held high.
   - Exactly 8 wr_en pulses, addresses 0..7 in order, data matches.
   - done=1 at edge 65; vld=1.
   - Drop req: done=0 one edge later.
2. Bad checksum: same image but word 7 = 0x00 -> done=1 at edge 65, vld=0.
3. Strobe timing: check every word with defaults -> address stable for 2 cycles before the strobe, strobe high exactly 4 cycles, address held 1 cycle after the strobe falls, no overlap between strobe and wr_en.
4. Abort: drop req during word 3's STROBE.
   - Next edge: IDLE, strobe=0, no further wr_en.
   - done=0, vld=0.
   - Re-raise req: a full load restarts at address 0.
5. Reset mid-load: i_rst=1 during word 5 WRITE -> all outputs 0 on the next edge; after release with req=1, a full reload completes with correct vld.
6. Back-to-back loads: after a pass load (vld=1), drop req, then request again with a corrupted checksum word -> vld clears at the start of the load and reads 0 at done.
